// File: rtl/cu_stage_monitor_if.sv
// Stage-strobe bus between the CU sequencer and the stage monitor:
// the five stage strobes and error clear toward the monitor, status back.
interface cu_stage_monitor_if #(
   parameter int CNT_W = 16
);
   logic             IF_clk;
   logic             ID_clk;
   logic             ALU_clk;
   logic             MEM_clk;
   logic             BR_clk;
   logic             err_clr;
   logic [2:0]       stage_code;
   logic             retire;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] cycle_count;
   logic             seq_err;
   logic [1:0]       err_kind;
   logic [2:0]       err_stage;

   modport master (
      output IF_clk, ID_clk, ALU_clk, MEM_clk, BR_clk, err_clr,
      input  stage_code, retire, instr_count, cycle_count, seq_err, err_kind, err_stage
   );

   modport slave (
      input  IF_clk, ID_clk, ALU_clk, MEM_clk, BR_clk, err_clr,
      output stage_code, retire, instr_count, cycle_count, seq_err, err_kind, err_stage
   );
endinterface

// File: rtl/cu_stage_monitor.sv
// Receive-side checker for the CU stage-strobe rotation IF->ID->ALU->MEM->BR->IF.
// Locks on an IF-only sample, counts retired instructions and tracked cycles,
// and latches the first protocol violation until err_clr.
module cu_stage_monitor #(
   parameter int CNT_W = 16
) (
   input  logic                 cpu_clk,
   input  logic                 reset,
   cu_stage_monitor_if.slave    bus
);
   typedef enum logic [1:0] {SYNC, TRACK, ERROR} state_t;

   localparam logic [4:0] OH_IF = 5'b10000;
   localparam logic [4:0] OH_ID = 5'b01000;

   state_t           state_q;
   logic [4:0]       exp_q;
   logic [2:0]       stage_code_q;
   logic             retire_q;
   logic [CNT_W-1:0] instr_q;
   logic [CNT_W-1:0] cycle_q;
   logic             seq_err_q;
   logic [1:0]       err_kind_q;
   logic [2:0]       err_stage_q;

   logic [4:0]       strobe_v;
   logic [4:0]       exp_d;
   logic [2:0]       exp_code;
   logic [1:0]       kind_d;
   logic [CNT_W-1:0] cycle_d;
   logic [CNT_W-1:0] instr_d;

   // Stage code 1..5 for a one-hot expected-stage vector (IF is the MSB).
   function automatic logic [2:0] code_of(input logic [4:0] oh);
      logic [2:0] c;
      case (oh)
         5'b10000: c = 3'd1;
         5'b01000: c = 3'd2;
         5'b00100: c = 3'd3;
         5'b00010: c = 3'd4;
         5'b00001: c = 3'd5;
         default:  c = 3'd0;
      endcase
      return c;
   endfunction

   // Decode the sampled strobes and precompute rotation, violation class and counter steps.
   always_comb begin
      strobe_v = {bus.IF_clk, bus.ID_clk, bus.ALU_clk, bus.MEM_clk, bus.BR_clk};
      exp_d    = {exp_q[0], exp_q[4:1]};
      exp_code = code_of(exp_q);
      if (strobe_v == 5'b00000)
         kind_d = 2'b01;
      else if ((strobe_v & (strobe_v - 5'd1)) != 5'b00000)
         kind_d = 2'b10;
      else
         kind_d = 2'b11;
      cycle_d  = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
      instr_d  = instr_q + 1'b1;
   end

   // Monitor FSM: every status output is registered from the same sample edge.
   always_ff @(posedge cpu_clk or negedge reset) begin
      if (!reset) begin
         state_q      <= SYNC;
         exp_q        <= OH_IF;
         stage_code_q <= 3'd0;
         retire_q     <= 1'b0;
         instr_q      <= '0;
         cycle_q      <= '0;
         seq_err_q    <= 1'b0;
         err_kind_q   <= 2'b00;
         err_stage_q  <= 3'd0;
      end else begin
         retire_q <= 1'b0;
         case (state_q)
            SYNC: begin
               // The locking IF sample is the first tracked cycle.
               if (strobe_v == OH_IF) begin
                  state_q      <= TRACK;
                  stage_code_q <= 3'd1;
                  exp_q        <= OH_ID;
                  cycle_q      <= cycle_d;
               end
            end
            TRACK: begin
               if (strobe_v == exp_q) begin
                  stage_code_q <= exp_code;
                  exp_q        <= exp_d;
                  cycle_q      <= cycle_d;
                  if (exp_q[0]) begin
                     retire_q <= 1'b1;
                     instr_q  <= instr_d;
                  end
               end else begin
                  state_q      <= ERROR;
                  seq_err_q    <= 1'b1;
                  err_kind_q   <= kind_d;
                  err_stage_q  <= exp_code;
                  stage_code_q <= 3'd7;
               end
            end
            ERROR: begin
               // Counters deliberately survive the clear; only reset zeroes them.
               if (bus.err_clr) begin
                  state_q      <= SYNC;
                  exp_q        <= OH_IF;
                  seq_err_q    <= 1'b0;
                  err_kind_q   <= 2'b00;
                  err_stage_q  <= 3'd0;
                  stage_code_q <= 3'd0;
               end
            end
            default: begin
               state_q <= SYNC;
               exp_q   <= OH_IF;
            end
         endcase
      end
   end

   assign bus.stage_code  = stage_code_q;
   assign bus.retire      = retire_q;
   assign bus.instr_count = instr_q;
   assign bus.cycle_count = cycle_q;
   assign bus.seq_err     = seq_err_q;
   assign bus.err_kind    = err_kind_q;
   assign bus.err_stage   = err_stage_q;
endmodule

// File: tb/tb_cu_stage_monitor.sv
// Bench for cu_stage_monitor: one 16-bit and one 4-bit counter instance share
// the same strobe stimulus; a stage-index reference model predicts all outputs.
module tb_cu_stage_monitor;
   logic       cpu_clk;
   logic       reset;
   logic [4:0] v_drv;
   logic       clr_drv;

   int total = 0;
   int bad   = 0;

   cu_stage_monitor_if #(.CNT_W(16)) b16 ();
   cu_stage_monitor_if #(.CNT_W(4))  b4  ();

   assign {b16.IF_clk, b16.ID_clk, b16.ALU_clk, b16.MEM_clk, b16.BR_clk} = v_drv;
   assign {b4.IF_clk,  b4.ID_clk,  b4.ALU_clk,  b4.MEM_clk,  b4.BR_clk}  = v_drv;
   assign b16.err_clr = clr_drv;
   assign b4.err_clr  = clr_drv;

   cu_stage_monitor #(.CNT_W(16)) u16 (.cpu_clk(cpu_clk), .reset(reset), .bus(b16.slave));
   cu_stage_monitor #(.CNT_W(4))  u4  (.cpu_clk(cpu_clk), .reset(reset), .bus(b4.slave));

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   // Reference model: mode 0 unlocked, 1 tracking, 2 error; stage index 0..4 = IF..BR.
   int m_mode, m_exp, m_code, m_kind, m_estage;
   int m_instr, m_cyc;
   bit m_err, m_ret;

   task automatic model_reset();
      m_mode = 0; m_exp = 0; m_code = 0; m_kind = 0; m_estage = 0;
      m_instr = 0; m_cyc = 0; m_err = 0; m_ret = 0;
   endtask

   task automatic model_step(input logic [4:0] v, input logic clr);
      logic [4:0] want;
      want  = 5'b10000 >> m_exp;
      m_ret = 0;
      if (m_mode == 0) begin
         if (v == 5'b10000) begin
            m_mode = 1; m_code = 1; m_exp = 1; m_cyc++;
         end
      end else if (m_mode == 1) begin
         if (v == want) begin
            m_code = m_exp + 1;
            m_cyc++;
            if (m_exp == 4) begin
               m_instr++; m_ret = 1;
            end
            m_exp = (m_exp + 1) % 5;
         end else begin
            m_mode   = 2;
            m_err    = 1;
            m_kind   = (v == 0) ? 1 : (($countones(v) > 1) ? 2 : 3);
            m_estage = m_exp + 1;
            m_code   = 7;
         end
      end else if (clr) begin
         m_mode = 0; m_exp = 0; m_err = 0; m_kind = 0; m_estage = 0; m_code = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int sat(input int x, input int maxv);
      return (x > maxv) ? maxv : x;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".code16"},  32'(b16.stage_code),  m_code);
      chk({tag, ".ret16"},   32'(b16.retire),      32'(m_ret));
      chk({tag, ".instr16"}, 32'(b16.instr_count), m_instr % 65536);
      chk({tag, ".cyc16"},   32'(b16.cycle_count), sat(m_cyc, 65535));
      chk({tag, ".err16"},   32'(b16.seq_err),     32'(m_err));
      chk({tag, ".kind16"},  32'(b16.err_kind),    m_kind);
      chk({tag, ".estg16"},  32'(b16.err_stage),   m_estage);
      chk({tag, ".code4"},   32'(b4.stage_code),   m_code);
      chk({tag, ".ret4"},    32'(b4.retire),       32'(m_ret));
      chk({tag, ".instr4"},  32'(b4.instr_count),  m_instr % 16);
      chk({tag, ".cyc4"},    32'(b4.cycle_count),  sat(m_cyc, 15));
      chk({tag, ".err4"},    32'(b4.seq_err),      32'(m_err));
      chk({tag, ".kind4"},   32'(b4.err_kind),     m_kind);
      chk({tag, ".estg4"},   32'(b4.err_stage),    m_estage);
   endtask

   task automatic step(input logic [4:0] v, input logic clr, input string tag);
      v_drv   = v;
      clr_drv = clr;
      @(posedge cpu_clk);
      model_step(v, clr);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b0;
      v_drv   = 5'b00000;
      clr_drv = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(posedge cpu_clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic rotations(input int n, input string tag);
      for (int r = 0; r < n; r++)
         for (int s = 0; s < 5; s++)
            step(5'b10000 >> s, 1'b0, tag);
   endtask

   initial begin
      logic [4:0] rv;
      logic       rc;
      reset   = 1'b0;
      v_drv   = 5'b00000;
      clr_drv = 1'b0;
      #2;

      // 1: three clean rotations from reset
      do_reset("rst1");
      rotations(3, "rot3");
      chk("t1.instr", 32'(b16.instr_count), 3);
      chk("t1.cycle", 32'(b16.cycle_count), 15);
      chk("t1.err",   32'(b16.seq_err),     0);

      // 2: all-low strobes at the ALU slot
      step(5'b10000, 1'b0, "t2.if");
      step(5'b01000, 1'b0, "t2.id");
      step(5'b00000, 1'b0, "t2.zero");
      chk("t2.kind",  32'(b16.err_kind),    1);
      chk("t2.estg",  32'(b16.err_stage),   3);
      chk("t2.code",  32'(b16.stage_code),  7);
      step(5'b00100, 1'b0, "t2.hold");
      step(5'b10000, 1'b0, "t2.hold2");
      step(5'b00000, 1'b1, "t2.clr");

      // 3: multi-hot at the ID slot, then clear
      step(5'b10000, 1'b0, "t3.lock");
      step(5'b11000, 1'b0, "t3.multi");
      chk("t3.kind",  32'(b16.err_kind),    2);
      chk("t3.estg",  32'(b16.err_stage),   2);
      step(5'b00000, 1'b1, "t3.clr");
      chk("t3.code",  32'(b16.stage_code),  0);
      chk("t3.instr", 32'(b16.instr_count), 3);

      // err_clr is ignored outside ERROR, and loses to a simultaneous violation
      step(5'b00000, 1'b1, "clr.sync");
      step(5'b10000, 1'b1, "clr.lock");
      step(5'b00100, 1'b1, "clr.wrong");
      chk("clr.kind", 32'(b16.err_kind), 3);
      step(5'b00000, 1'b1, "clr.clear");

      // 4: stray strobes before any IF after reset
      do_reset("rst4");
      step(5'b01000, 1'b0, "t4.id");
      step(5'b00100, 1'b0, "t4.alu");
      step(5'b11111, 1'b0, "t4.all");
      step(5'b10000, 1'b0, "t4.lock");
      chk("t4.code", 32'(b16.stage_code), 1);

      // 5: wrap and saturation on the narrow instance
      do_reset("rst5");
      rotations(17, "rot17");
      chk("t5.instr4", 32'(b4.instr_count),  1);
      chk("t5.cyc4",   32'(b4.cycle_count),  15);
      chk("t5.cyc16",  32'(b16.cycle_count), 85);

      // 6: asynchronous reset in the middle of the MEM cycle
      step(5'b10000, 1'b0, "t6.if");
      step(5'b01000, 1'b0, "t6.id");
      step(5'b00100, 1'b0, "t6.alu");
      step(5'b00010, 1'b0, "t6.mem");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("t6.async");
      chk("t6.instr0", 32'(b16.instr_count), 0);
      @(negedge cpu_clk);
      reset = 1'b1;
      step(5'b10000, 1'b0, "t6.relock");
      chk("t6.code", 32'(b16.stage_code), 1);

      // Randomized mix of legal rotation, stray vectors and clears
      for (int i = 0; i < 400; i++) begin
         rc = ($urandom_range(0, 9) == 0);
         if (m_mode == 1 && $urandom_range(0, 19) != 0)
            rv = 5'b10000 >> m_exp;
         else if (m_mode == 0 && $urandom_range(0, 1) == 0)
            rv = 5'b10000;
         else
            rv = 5'($urandom_range(0, 31));
         if (m_mode == 2 && $urandom_range(0, 4) == 0)
            rc = 1'b1;
         step(rv, rc, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
